// File: rtl/clock_hex_display_if.sv
// Display-side bundle between the timer and the HH:MM:SS seven-segment driver.
// Carries binary time fields in (i_*) and the six segment digits plus status out (o_*).
// Ports: i_seconds/i_minutes/i_hours (timer -> display), o_hex0..5, o_busy, o_update (display -> board).
interface clock_hex_display_if;
  logic [5:0] i_seconds;
  logic [5:0] i_minutes;
  logic [6:0] i_hours;
  logic [6:0] o_hex0;
  logic [6:0] o_hex1;
  logic [6:0] o_hex2;
  logic [6:0] o_hex3;
  logic [6:0] o_hex4;
  logic [6:0] o_hex5;
  logic       o_busy;
  logic       o_update;

  // Timer / board side: drives time, observes digits.
  modport master (
    output i_seconds, i_minutes, i_hours,
    input  o_hex0, o_hex1, o_hex2, o_hex3, o_hex4, o_hex5, o_busy, o_update
  );

  // Display driver side.
  modport slave (
    input  i_seconds, i_minutes, i_hours,
    output o_hex0, o_hex1, o_hex2, o_hex3, o_hex4, o_hex5, o_busy, o_update
  );
endinterface

// File: rtl/clock_hex_display.sv
// Purpose: snapshot timer seconds/minutes/hours and drive six static active-low 7-seg digits (HH:MM:SS).
// Latency: digits commit (tens_s+1)+(tens_m+1)+(tens_h+1)+1 edges after the snapshot edge.
// Backpressure: none; refresh ticks arriving while a conversion runs are dropped, not queued.
//
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   bus.i_seconds    - 6-bit binary seconds      bus.o_hex0/1 - seconds ones/tens
//   bus.i_minutes    - 6-bit binary minutes      bus.o_hex2/3 - minutes ones/tens
//   bus.i_hours      - 7-bit binary hours        bus.o_hex4/5 - hours ones/tens
//   bus.o_busy       - high while converting     bus.o_update - one-cycle pulse on commit
// Segment encoding: active-low, bit0 = a .. bit6 = g.
// Optional build macro LEADING_ZERO_BLANK_EN: blank the hours tens digit when it is zero.
// REFRESH_DIV = CLOCK_FREQ / REFRESH_HZ must be at least 32 so a full conversion
// (at most 7+7+10+1 cycles) always finishes before the next tick.
module clock_hex_display #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int REFRESH_HZ = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  clock_hex_display_if.slave   bus
);

  localparam int REFRESH_DIV = CLOCK_FREQ / REFRESH_HZ;
  localparam int CNT_W       = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_ZERO  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HEX5_RST = SEG_BLANK;
`else
  localparam logic [6:0] HEX5_RST = SEG_ZERO;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONV_S = 3'd1,
    CONV_M = 3'd2,
    CONV_H = 3'd3,
    COMMIT = 3'd4
  } state_t;

  // Decimal digit to active-low segment pattern.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Refresh divider: free-running, terminal count is the snapshot tick.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Conversion state and working registers.
  // r_rem holds the field being reduced; seconds go straight into it at the
  // snapshot, minutes and hours wait in their own snapshot registers.
  // ---------------------------------------------------------------------------
  state_t     r_state;
  logic [6:0] r_rem;
  logic [3:0] r_tens;
  logic [5:0] r_min_snap;
  logic [6:0] r_hr_snap;
  logic [3:0] r_s_tens, r_s_ones;
  logic [3:0] r_m_tens, r_m_ones;
  logic [3:0] r_h_tens, r_h_ones;
  logic       r_h_dash;
  logic [6:0] r_hex0, r_hex1, r_hex2, r_hex3, r_hex4, r_hex5;
  logic       r_busy;
  logic       r_update;

  logic       w_rem_ge10;
  logic [6:0] w_hex4_nxt;
  logic [6:0] w_hex5_nxt;

  assign w_rem_ge10 = (r_rem >= 7'd10);

  // Hours digit patterns, resolved from the latched BCD and the dash flag.
  always_comb begin
    w_hex4_nxt = seg7(r_h_ones);
    w_hex5_nxt = seg7(r_h_tens);
    if (r_h_dash) begin
      w_hex4_nxt = SEG_DASH;
      w_hex5_nxt = SEG_DASH;
    end
`ifdef LEADING_ZERO_BLANK_EN
    else if (r_h_tens == 4'd0) begin
      w_hex5_nxt = SEG_BLANK;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rem      <= '0;
      r_tens     <= '0;
      r_min_snap <= '0;
      r_hr_snap  <= '0;
      r_s_tens   <= '0;
      r_s_ones   <= '0;
      r_m_tens   <= '0;
      r_m_ones   <= '0;
      r_h_tens   <= '0;
      r_h_ones   <= '0;
      r_h_dash   <= 1'b0;
      r_hex0     <= SEG_ZERO;
      r_hex1     <= SEG_ZERO;
      r_hex2     <= SEG_ZERO;
      r_hex3     <= SEG_ZERO;
      r_hex4     <= SEG_ZERO;
      r_hex5     <= HEX5_RST;
      r_busy     <= 1'b0;
      r_update   <= 1'b0;
    end else begin
      r_update <= 1'b0;
      case (r_state)
        IDLE: begin
          // Coherent snapshot: all three fields sampled on the tick edge.
          if (w_tick) begin
            r_rem      <= {1'b0, bus.i_seconds};
            r_min_snap <= bus.i_minutes;
            r_hr_snap  <= bus.i_hours;
            r_tens     <= '0;
            r_busy     <= 1'b1;
            r_state    <= CONV_S;
          end
        end

        CONV_S: begin
          if (w_rem_ge10) begin
            r_rem  <= r_rem - 7'd10;
            r_tens <= r_tens + 4'd1;
          end else begin
            r_s_tens <= r_tens;
            r_s_ones <= r_rem[3:0];
            r_rem    <= {1'b0, r_min_snap};
            r_tens   <= '0;
            r_state  <= CONV_M;
          end
        end

        CONV_M: begin
          if (w_rem_ge10) begin
            r_rem  <= r_rem - 7'd10;
            r_tens <= r_tens + 4'd1;
          end else begin
            r_m_tens <= r_tens;
            r_m_ones <= r_rem[3:0];
            r_rem    <= r_hr_snap;
            r_tens   <= '0;
            r_state  <= CONV_H;
          end
        end

        CONV_H: begin
          // r_rem can only be >= 100 on the first CONV_H cycle: subtraction
          // never starts for such values, so this is the on-entry range check.
          if (r_rem >= 7'd100) begin
            r_h_dash <= 1'b1;
            r_state  <= COMMIT;
          end else if (w_rem_ge10) begin
            r_rem  <= r_rem - 7'd10;
            r_tens <= r_tens + 4'd1;
          end else begin
            r_h_dash <= 1'b0;
            r_h_tens <= r_tens;
            r_h_ones <= r_rem[3:0];
            r_state  <= COMMIT;
          end
        end

        COMMIT: begin
          // All six digits change together so the display never shows a mix
          // of old and new time.
          r_hex0   <= seg7(r_s_ones);
          r_hex1   <= seg7(r_s_tens);
          r_hex2   <= seg7(r_m_ones);
          r_hex3   <= seg7(r_m_tens);
          r_hex4   <= w_hex4_nxt;
          r_hex5   <= w_hex5_nxt;
          r_update <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_hex0   = r_hex0;
  assign bus.o_hex1   = r_hex1;
  assign bus.o_hex2   = r_hex2;
  assign bus.o_hex3   = r_hex3;
  assign bus.o_hex4   = r_hex4;
  assign bus.o_hex5   = r_hex5;
  assign bus.o_busy   = r_busy;
  assign bus.o_update = r_update;

endmodule
